btn_act_conditioner: RTL
========================

Name: btn_act_conditioner

Overview:
- Upstream stage of the tile-rotation play controller.
- Converts four raw, bouncing, asynchronous push-buttons into clean single-cycle one-hot act[3:0] pulses in the clk_d domain.
- The controller applies one rotation per clk_d cycle that act is non-zero, so this block guarantees:
  - at most one act bit per cycle;
  - a configurable idle gap between pulses;
  - no lost presses, via a one-deep pending flag per button.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clk_d samples a synchronized input must differ from the debounced level before the new level is accepted (>=1).
- LOCKOUT, 2, number of forced-zero act cycles after every issued pulse (>=0).

Ports:
- clk_d  input  1  game clock (divided clock, same domain as the play controller).
- reset  input  1  asynchronous, active-low reset; clears all state while low.
- start  input  1  game-run enable, same meaning as the controller's start.
- btn_raw  input  4  raw button levels, asynchronous, active-high; bit i maps to act[i].
- act  output  4  one-hot press pulse, registered, high for exactly one clk_d cycle.
- btn_level  output  4  debounced button levels, registered.
- busy  output  1  registered; 1 when the lockout counter is non-zero or any pending bit is set.

Behaviour:
- Reset (reset=0, asynchronous), all cleared to 0:
  - act, btn_level, busy
  - sync stages s1/s2
  - debounce counters
  - pending[3:0]
  - lockout counter
- Reset mid-operation discards in-flight presses; after release the first sampled high raw level starts a fresh debounce.
- Synchronizer: two flops per bit (s1<=btn_raw, s2<=s1), no reset-free flops.
- Debounce, per bit i, counter width clog2(DEBOUNCE_CYCLES+1):
  - s2[i]==btn_level[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: btn_level[i]<=s2[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES samples resets the count and never changes btn_level.
- Press event: on the edge where btn_level[i] transitions 0->1, pending[i]<=1 on that same edge.
  - Releases (1->0) generate nothing.
  - A press while pending[i] is already 1 leaves it 1 (no counting).
- Issue, evaluated every edge with start=1:
  - If lockout==0 and pending!=0: act<=one-hot of the lowest-index set pending bit, that pending bit clears, lockout<=LOCKOUT.
  - Otherwise act<=0, and lockout decrements if non-zero.
- Simultaneous events:
  - If a new press event on bit i coincides with issuing bit i, the set wins and pending[i] stays 1.
  - Bits not issued retain pending.
- start=0: act<=0, pending<=0, lockout<=0, every cycle. Debounce and btn_level keep running. A button held across the start rising edge does not produce a pulse.
- Latency:
  - Count the first edge sampling btn_raw=1 as edge 1.
  - btn_level=1 after edge DEBOUNCE_CYCLES+2.
  - act pulse visible after edge DEBOUNCE_CYCLES+3 (edge 7 at default), for one cycle.
- Spacing: consecutive pulses are exactly LOCKOUT+1 edges apart when work is pending. With LOCKOUT=0, back-to-back pulses are legal.
- busy is registered from next-state values: busy <= (lockout_next!=0) | (pending_next!=0).
- Invariant, checked by assertion: act is always one-hot or zero.

Test Plan:
- Reset, then btn_raw=4'b0010 held steady with start=1 → act=4'b0010 for exactly one cycle after edge 7; btn_level[1]=1 after edge 6; no second pulse while held.
- Bounce: btn_raw[0] toggles 1,0,1,1,0 (each held 1 cycle), then stable 1 → btn_level[0] rises only after 4 consecutive stable samples; exactly one act=4'b0001 pulse.
- Simultaneous press of bits 3 and 0 (same edge) → act=4'b0001, then act=0 for 2 cycles, then act=4'b1000; busy=1 from pending set until the last lockout cycle ends.
- Press bit 2 during lockout → pulse deferred to the first cycle with lockout==0, not dropped; press-release-press of bit 2 within a single lockout yields one pulse only.
- start=0 while pending=4'b0110 → act stays 0, pending cleared, busy=0 next cycle; raising start with bit 1 still held → no pulse until released and re-pressed.
- Assert reset low mid-debounce (cnt=2) and mid-lockout → all outputs 0 immediately (asynchronous); after release, held button 3 produces act=4'b1000 at edge 7 relative to the first post-reset sample.

Source files
------------

// File: rtl/btn_act_conditioner.sv
// Push-button conditioner: synchronizes, debounces and arbitrates four raw
// buttons into one-hot single-cycle act pulses separated by a lockout gap.
module btn_act_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT         = 2
) (
    input  logic       clk_d,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn_raw,
    output logic [3:0] act,
    output logic [3:0] btn_level,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [CW-1:0] cnt [4];
    logic [3:0]    pending;
    logic [LW-1:0] lockout;

    logic [3:0]    accept;
    logic [3:0]    rise;
    logic [3:0]    grant;
    logic [3:0]    act_next;
    logic [3:0]    pending_next;
    logic [LW-1:0] lockout_next;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            accept[i] = (s2[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
        end
        rise = accept & s2 & ~btn_level;
        // Isolate the lowest set pending bit (fixed priority, bit 0 first).
        grant = pending & (~pending + 4'd1);

        act_next     = 4'b0;
        pending_next = 4'b0;
        lockout_next = '0;
        if (start) begin
            if (lockout == '0 && pending != 4'b0) begin
                act_next     = grant;
                pending_next = (pending & ~grant) | rise;
                lockout_next = LOCK_LOAD;
            end else begin
                pending_next = pending | rise;
                lockout_next = (lockout != '0) ? lockout - LW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk_d or negedge reset) begin
        if (!reset) begin
            s1        <= 4'b0;
            s2        <= 4'b0;
            btn_level <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            pending   <= 4'b0;
            lockout   <= '0;
            act       <= 4'b0;
            busy      <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    btn_level[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            pending <= pending_next;
            lockout <= lockout_next;
            act     <= act_next;
            busy    <= (lockout_next != '0) || (pending_next != 4'b0);
        end
    end

    a_act_onehot: assert property (
        @(posedge clk_d) disable iff (!reset) $onehot0(act)
    );

endmodule
